udp_tx_scheduler: RTL and testbench

UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

---
 rtl/udp_tx_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a UDP transmitter with inter-frame gap control.
// Optional WAIT_TXEN/BUSY watchdog is compiled in when UDP_TX_SCHED_TIMEOUT_EN is defined.
module udp_tx_scheduler #(
  parameter int IFG_CYCLES     = 12,
  parameter int MAX_PAYLOAD    = 1472,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] req_len0,
  input  logic [15:0] req_len1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        tx_start,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  input  logic        tx_txen,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_timeout
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_TXEN = 3'd2,
    S_BUSY      = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               served_q, served_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         done_q, done_d;
  logic               tx_start_q, tx_start_d;
  logic [15:0]        data_len_q, data_len_d;
  logic [15:0]        total_len_q, total_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
`else
  logic               unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Round-robin winner: the pointer's requester if asking, otherwise the other one.
  logic        winner;
  logic [15:0] sel_len;
  logic [16:0] len_round;
  logic [15:0] len_final;

  always_comb begin
    winner    = req[ptr_q] ? ptr_q : ~ptr_q;
    sel_len   = winner ? req_len1 : req_len0;
    // 17-bit sum so that 0xFFFD..0xFFFF round up without wrapping to zero.
    len_round = ({1'b0, sel_len} + 17'd3) & ~17'd3;
    if (len_round == 17'd0) begin
      len_final = 16'd4;
    end else if (len_round > 17'(MAX_PAYLOAD)) begin
      len_final = 16'(MAX_PAYLOAD);
    end else begin
      len_final = len_round[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    served_d    = served_q;
    grant_d     = 2'b00;
    done_d      = 2'b00;
    tx_start_d  = 1'b0;
    data_len_d  = data_len_q;
    total_len_d = total_len_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d     = winner ? 2'b10 : 2'b01;
          served_d    = winner;
          ptr_d       = ~winner;
          data_len_d  = len_final + 16'd8;
          total_len_d = len_final + 16'd28;
          state_d     = S_START;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TXEN;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        wd_d       = '0;
`endif
      end
      S_WAIT_TXEN: begin
        if (tx_txen) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!tx_txen) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          done_d      = served_q ? 2'b10 : 2'b01;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    // Watchdog overrides the normal WAIT_TXEN/BUSY transitions once it expires.
    if (state_q == S_WAIT_TXEN || state_q == S_BUSY) begin
      if (wd_q == WD_LAST) begin
        state_d   = S_GAP;
        gap_cnt_d = GAP_LOAD;
        err_d     = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      served_q    <= 1'b0;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      tx_start_q  <= 1'b0;
      data_len_q  <= 16'd0;
      total_len_q <= 16'd0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= 16'd0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      served_q    <= served_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      tx_start_q  <= tx_start_d;
      data_len_q  <= data_len_d;
      total_len_q <= total_len_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign grant           = grant_q;
  assign done            = done_q;
  assign tx_start        = tx_start_q;
  assign tx_data_length  = data_len_q;
  assign tx_total_length = total_len_q;
  assign busy            = (state_q != S_IDLE);
  assign frame_cnt       = frame_cnt_q;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
  assign err_timeout     = err_q;
`else
  assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: stimulus queues expected grants/dones, a monitor checks them.
module tb_udp_tx_scheduler;

  localparam int IFG = 12;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
  localparam int TB_TIMEOUT = 64;
  localparam int A_TXEN     = 50;
`else
  localparam int TB_TIMEOUT = 4096;
  localparam int A_TXEN     = 150;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_len0, req_len1;
  logic [1:0]  grant, done;
  logic        tx_start;
  logic [15:0] tx_data_length, tx_total_length;
  logic        tx_txen;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_timeout;

  udp_tx_scheduler #(
    .IFG_CYCLES(IFG),
    .MAX_PAYLOAD(1472),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len0(req_len0), .req_len1(req_len1),
    .grant(grant), .done(done), .tx_start(tx_start),
    .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
    .tx_txen(tx_txen), .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  who;
    logic [15:0] dl;
    logic [15:0] tl;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_g[$];
  exp_t exp_d[$];

  int checks   = 0;
  int failures = 0;
  int txen_len = 10;

  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min_v);
    checks++;
    if (act < min_v) begin
      failures++;
      $display("FAIL %s actual=%0d required>=%0d", name, act, min_v);
    end
  endtask

  task automatic push(input logic [1:0] w, input logic [15:0] dl, input logic [15:0] tl,
                      input logic [15:0] fc, input bit with_done);
    exp_t e;
    e.who = w; e.dl = dl; e.tl = tl; e.fc = fc;
    exp_g.push_back(e);
    if (with_done) exp_d.push_back(e);
  endtask

  // Transmitter model: raises txen two cycles after tx_start for txen_len cycles (never if 0).
  initial begin
    int  phase;
    bit  active;
    tx_txen = 1'b0;
    phase   = 0;
    active  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        tx_txen = 1'b0;
        active  = 1'b0;
      end else if (!active && tx_start && txen_len > 0) begin
        active = 1'b1;
        phase  = 0;
      end else if (active) begin
        phase++;
        if (phase == 2) tx_txen = 1'b1;
        else if (phase == 2 + txen_len) begin
          tx_txen = 1'b0;
          active  = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int   cyc, fall_cyc;
    bit   start_due, gap_valid, frame_fall, prev_txen;
    exp_t e;
    cyc = 0; fall_cyc = 0;
    start_due = 0; gap_valid = 0; frame_fall = 0; prev_txen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        start_due = 0; gap_valid = 0; frame_fall = 0; prev_txen = 0;
      end else begin
        if (prev_txen && !tx_txen) begin
          fall_cyc = cyc; gap_valid = 1; frame_fall = 1;
        end
        prev_txen = tx_txen;
        if (start_due) begin
          chk("tx_start_latency", int'(tx_start), 1);
          if (gap_valid) chk_ge("ifg_gap", cyc - fall_cyc, IFG);
          start_due = 0;
        end else if (tx_start) begin
          chk("tx_start_spurious", int'(tx_start), 0);
        end
        if (done != 2'b00) begin
          if (exp_d.size() == 0) begin
            chk("done_unexpected", int'(done), 0);
          end else begin
            e = exp_d.pop_front();
            $display("done  cyc=%0d done=%b frame_cnt=%0d", cyc, done, frame_cnt);
            chk("done_who", int'(done), int'(e.who));
            chk("frame_cnt", int'(frame_cnt), int'(e.fc));
            chk("data_len_held", int'(tx_data_length), int'(e.dl));
            chk("total_len_held", int'(tx_total_length), int'(e.tl));
            if (frame_fall) chk("done_delay", cyc - fall_cyc, IFG + 1);
          end
        end
        if (grant != 2'b00) begin
          if (exp_g.size() == 0) begin
            chk("grant_unexpected", int'(grant), 0);
          end else begin
            e = exp_g.pop_front();
            $display("grant cyc=%0d grant=%b data_len=%0d total_len=%0d",
                     cyc, grant, tx_data_length, tx_total_length);
            chk("grant_who", int'(grant), int'(e.who));
            chk("data_len", int'(tx_data_length), int'(e.dl));
            chk("total_len", int'(tx_total_length), int'(e.tl));
          end
          start_due  = 1;
          frame_fall = 0;
        end
      end
    end
  end

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_data_len"}, int'(tx_data_length), 0);
    chk({tag, "_total_len"}, int'(tx_total_length), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    chk({tag, "_err_timeout"}, int'(err_timeout), 0);
    rst = 1'b0;
  endtask

  // Holds req until n frames completed; single frames drop req and scramble lengths after grant.
  task automatic run_frames(input logic [1:0] r, input logic [15:0] l0, input logic [15:0] l1,
                            input int n, input int tl);
    int ng, nd, budget;
    ng = 0; nd = 0; budget = 0;
    txen_len = tl;
    @(negedge clk);
    req = r; req_len0 = l0; req_len1 = l1;
    while (nd < n && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (grant != 2'b00) begin
        ng++;
        if (n == 1) begin
          req = 2'b00; req_len0 = 16'hFFFF; req_len1 = 16'h0001;
        end
      end
      if (done != 2'b00) nd++;
    end
    req = 2'b00;
    chk("frames_completed", nd, n);
  endtask

  initial begin
    int budget;
    rst = 1'b1; req = 2'b00; req_len0 = 16'd0; req_len1 = 16'd0;
    repeat (3) @(negedge clk);
    pulse_reset("reset");

    // Single frame from requester 0.
    push(2'b01, 16'd108, 16'd128, 16'd1, 1);
    run_frames(2'b01, 16'd100, 16'd0, 1, A_TXEN);

    // Both requesting from a fresh pointer: strict alternation.
    pulse_reset("reset2");
    push(2'b01, 16'd28, 16'd48, 16'd1, 1);
    push(2'b10, 16'd44, 16'd64, 16'd2, 1);
    push(2'b01, 16'd28, 16'd48, 16'd3, 1);
    push(2'b10, 16'd44, 16'd64, 16'd4, 1);
    run_frames(2'b11, 16'd20, 16'd36, 4, 10);

    // Length rounding and saturation.
    push(2'b01, 16'd12, 16'd32, 16'd5, 1);
    run_frames(2'b01, 16'd0, 16'd0, 1, 6);
    push(2'b01, 16'd16, 16'd36, 16'd6, 1);
    run_frames(2'b01, 16'd5, 16'd0, 1, 6);
    push(2'b01, 16'd1480, 16'd1500, 16'd7, 1);
    run_frames(2'b01, 16'd2000, 16'd0, 1, 6);
    push(2'b10, 16'd1480, 16'd1500, 16'd8, 1);
    run_frames(2'b10, 16'd0, 16'd1471, 1, 6);

    // Reset while BUSY: aborted frame gives no done; pointer restarts at requester 0.
    push(2'b10, 16'd48, 16'd68, 16'd0, 0);
    txen_len = 200;
    @(negedge clk);
    req = 2'b10; req_len1 = 16'd40;
    budget = 0;
    while (!(busy && tx_txen) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (grant != 2'b00) req = 2'b00;
    end
    chk("reached_busy", int'(busy && tx_txen), 1);
    repeat (5) @(negedge clk);
    pulse_reset("midframe_reset");
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", int'(frame_cnt), 0);
    push(2'b01, 16'd16, 16'd36, 16'd1, 1);
    run_frames(2'b11, 16'd8, 16'd12, 1, 8);

    // Transmitter never asserts txen.
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    push(2'b01, 16'd24, 16'd44, 16'd2, 1);
    run_frames(2'b01, 16'd16, 16'd0, 1, 0);
    chk("err_timeout_set", int'(err_timeout), 1);
    repeat (10) @(negedge clk);
    chk("err_timeout_sticky", int'(err_timeout), 1);
`else
    push(2'b01, 16'd24, 16'd44, 16'd0, 0);
    txen_len = 0;
    @(negedge clk);
    req = 2'b01; req_len0 = 16'd16;
    budget = 0;
    while (grant == 2'b00 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    req = 2'b00;
    repeat (150) @(negedge clk);
    chk("stuck_busy", int'(busy), 1);
    chk("no_err_timeout", int'(err_timeout), 0);
    chk("stuck_frame_cnt", int'(frame_cnt), 1);
`endif
    pulse_reset("final_reset");

    chk("pending_grants", exp_g.size(), 0);
    chk("pending_dones", exp_d.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
